// File: rtl/systolic_mac_pe_if.sv
// Neighbour-facing bundle of one systolic MAC processing element.
// The slave side is the PE itself; the master side is whatever feeds it (upstream PE or controller).
interface systolic_mac_pe_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
);
    logic              mode;
    logic              in_valid;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              w_load;
    logic [DATA_W-1:0] w_in;
    logic [ACC_W-1:0]  in_c;
    logic              in_c_valid;
    logic              acc_clr;
    logic              drain;
    logic              out_valid;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [DATA_W-1:0] out_w;
    logic [ACC_W-1:0]  out_c;
    logic              out_c_valid;
    logic              sat;

    modport slave (
        input  mode, in_valid, in_a, in_b, w_load, w_in, in_c, in_c_valid, acc_clr, drain,
        output out_valid, out_a, out_b, out_w, out_c, out_c_valid, sat
    );

    modport master (
        output mode, in_valid, in_a, in_b, w_load, w_in, in_c, in_c_valid, acc_clr, drain,
        input  out_valid, out_a, out_b, out_w, out_c, out_c_valid, sat
    );
endinterface

// File: rtl/systolic_mac_pe.sv
// Systolic-array MAC cell with runtime weight-stationary / output-stationary dataflow,
// daisy-chained weight load and optional saturating accumulation with a sticky overflow flag.
module systolic_mac_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter bit SAT_EN = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    systolic_mac_pe_if.slave    bus
);

    localparam int PROD_W = 2 * DATA_W;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Sum one guard bit wide; MSB of the result flags overflow, the rest is the clamped or wrapped sum.
    function automatic logic [ACC_W:0] add_sum(input logic [ACC_W-1:0] x, input logic [ACC_W-1:0] y);
        logic [ACC_W:0]   s;
        logic             ovf;
        logic [ACC_W-1:0] r;
        s   = {x[ACC_W-1], x} + {y[ACC_W-1], y};
        ovf = s[ACC_W] ^ s[ACC_W-1];
        if (!ovf) begin
            r = s[ACC_W-1:0];
        end else if (SAT_EN) begin
            r = s[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            r = s[ACC_W-1:0];
        end
        return {ovf, r};
    endfunction

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_a_q, out_a_d;
    logic [DATA_W-1:0] out_b_q, out_b_d;
    logic [DATA_W-1:0] w_q, w_d;
    logic [ACC_W-1:0]  out_c_q, out_c_d;
    logic              out_c_valid_q, out_c_valid_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              mode_q, mode_d;
    logic              sat_q, sat_d;

    logic [DATA_W-1:0] mul_b_s;
    logic [PROD_W-1:0] a_ext_s;
    logic [PROD_W-1:0] b_ext_s;
    logic [PROD_W-1:0] prod_s;
    logic [ACC_W-1:0]  prod_ext_s;
    logic [ACC_W-1:0]  ws_addend_s;
    logic [ACC_W:0]    ws_res_s;
    logic [ACC_W:0]    os_res_s;
    logic              mode_chg_s;

    // Signed product; the low PROD_W bits of the sign-extended operands' product are the exact result.
    always_comb begin
        if (bus.mode) begin
            mul_b_s = bus.in_b;
        end else begin
            mul_b_s = w_q;
        end
        a_ext_s    = {{DATA_W{bus.in_a[DATA_W-1]}}, bus.in_a};
        b_ext_s    = {{DATA_W{mul_b_s[DATA_W-1]}}, mul_b_s};
        prod_s     = a_ext_s * b_ext_s;
        prod_ext_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
        if (bus.in_valid) begin
            ws_addend_s = prod_ext_s;
        end else begin
            ws_addend_s = {ACC_W{1'b0}};
        end
        ws_res_s   = add_sum(bus.in_c, ws_addend_s);
        os_res_s   = add_sum(acc_q, prod_ext_s);
        mode_chg_s = (bus.mode != mode_q);
    end

    // Next-state for the pass-through, weight, partial-sum chain, accumulator and overflow flag.
    always_comb begin
        out_valid_d   = bus.in_valid;
        out_a_d       = out_a_q;
        out_b_d       = out_b_q;
        w_d           = w_q;
        out_c_d       = out_c_q;
        out_c_valid_d = out_c_valid_q;
        acc_d         = acc_q;
        mode_d        = bus.mode;
        sat_d         = sat_q;

        if (bus.in_valid) begin
            out_a_d = bus.in_a;
            out_b_d = bus.in_b;
        end else begin
            out_a_d = out_a_q;
            out_b_d = out_b_q;
        end

        if (bus.w_load) begin
            w_d = bus.w_in;
        end else begin
            w_d = w_q;
        end

        if (!bus.mode) begin
            out_c_d       = ws_res_s[ACC_W-1:0];
            out_c_valid_d = bus.in_c_valid;
        end else if (bus.drain) begin
            // Drain takes precedence; a colliding in_c is dropped.
            out_c_d       = acc_q;
            out_c_valid_d = 1'b1;
        end else begin
            out_c_d       = bus.in_c;
            out_c_valid_d = bus.in_c_valid;
        end

        if (mode_chg_s) begin
            acc_d = {ACC_W{1'b0}};
        end else if (!bus.mode) begin
            acc_d = acc_q;
        end else if (bus.acc_clr && bus.in_valid) begin
            acc_d = prod_ext_s;
        end else if (bus.acc_clr) begin
            acc_d = {ACC_W{1'b0}};
        end else if (bus.in_valid) begin
            acc_d = os_res_s[ACC_W-1:0];
        end else begin
            acc_d = acc_q;
        end

        // acc_clr starts a new tile in either mode, but never masks an overflow raised this cycle.
        if (!bus.mode) begin
            sat_d = ws_res_s[ACC_W] | (sat_q & ~bus.acc_clr);
        end else if (!mode_chg_s && !bus.acc_clr && bus.in_valid) begin
            sat_d = os_res_s[ACC_W] | sat_q;
        end else begin
            sat_d = sat_q & ~bus.acc_clr;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_a_q       <= {DATA_W{1'b0}};
            out_b_q       <= {DATA_W{1'b0}};
            w_q           <= {DATA_W{1'b0}};
            out_c_q       <= {ACC_W{1'b0}};
            out_c_valid_q <= 1'b0;
            acc_q         <= {ACC_W{1'b0}};
            mode_q        <= 1'b0;
            sat_q         <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_a_q       <= out_a_d;
            out_b_q       <= out_b_d;
            w_q           <= w_d;
            out_c_q       <= out_c_d;
            out_c_valid_q <= out_c_valid_d;
            acc_q         <= acc_d;
            mode_q        <= mode_d;
            sat_q         <= sat_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_a       = out_a_q;
    assign bus.out_b       = out_b_q;
    assign bus.out_w       = w_q;
    assign bus.out_c       = out_c_q;
    assign bus.out_c_valid = out_c_valid_q;
    assign bus.sat         = sat_q;

endmodule
